// File: rtl/fft_pkg.sv
// Shared definitions for the FFT stage sequencer.
// Contents: sequencer state encoding, pipeline-latency function and width helpers
// used to size the address, twiddle, stage and drain-counter fields.
package fft_pkg;

    // Sequencer states, kept as plain constants for legacy tool compatibility.
    typedef logic [1:0] fft_seq_state_t;
    localparam fft_seq_state_t StIdle  = 2'd0;
    localparam fft_seq_state_t StIssue = 2'd1;
    localparam fft_seq_state_t StDrain = 2'd2;
    localparam fft_seq_state_t StDone  = 2'd3;

    // Read-issue to write-back delay.
    function automatic int unsigned pipe_lat(input int unsigned rd_lat,
                                             input int unsigned bf_lat);
        return rd_lat + bf_lat;
    endfunction

    // Twiddle ROM index width: N/2 entries.
    function automatic int unsigned tw_width(input int unsigned n_log2);
        return n_log2 - 1;
    endfunction

    // Stage counter width; must hold N_LOG2-1.
    function automatic int unsigned stage_width(input int unsigned n_log2);
        return (n_log2 < 2) ? 1 : $clog2(n_log2);
    endfunction

    // Drain counter width; must hold PIPE_LAT.
    function automatic int unsigned cnt_width(input int unsigned plat);
        return (plat < 1) ? 1 : $clog2(plat + 1);
    endfunction

endpackage

// File: rtl/fft_wr_delay_line.sv
// Fixed-depth shift register carrying write-back information (valid, addresses and,
// when enabled, the scale bit) from the read-issue side to the write side.
// Ports:
//   clk_i  - clock
//   rst_ni - synchronous active-low clear of every stage
//   d_i    - word entering the line each cycle
//   q_o    - word delayed by Depth cycles
module fft_wr_delay_line #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] pipe_q [Depth];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < Depth; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= d_i;
            for (int i = 1; i < Depth; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign q_o = pipe_q[Depth-1];

endmodule

// File: rtl/fft_stage_sequencer.sv
// Sequences in-place radix-2 DIT FFT/IFFT passes over the sample RAM: issues butterfly
// reads with twiddle indices, produces delayed write-back addresses, drains the pipeline
// between stages and pulses done after the final stage.
// Optional feature: define FFT_STAGE_SCALE_EN for a per-stage divide-by-2 (bf_scale_o /
// wr_scale_o). Without it both scale outputs are tied to 0.
// Ports:
//   clk_i, rst_ni             - clock, synchronous active-low reset
//   start_i, is_ifft_i        - begin transform (IDLE only), direction latched at start
//   bf_ready_i                - butterfly accepts an issue this cycle
//   rd_en_o, rd_addr_a/b_o    - butterfly read issue and leg addresses
//   tw_idx_o, tw_conj_o       - twiddle index and conjugate flag (valid with rd_en_o)
//   bf_scale_o                - halve butterfly outputs (valid with rd_en_o)
//   wr_en_o, wr_addr_a/b_o    - write-back, PIPE_LAT cycles after the matching read
//   wr_scale_o                - bf_scale_o delayed to the write side
//   stage_o, busy_o, done_o   - current stage, not-idle flag, completion pulse
module fft_stage_sequencer
    import fft_pkg::*;
#(
    parameter int unsigned N_LOG2 = 10,
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned BF_LAT = 3
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              start_i,
    input  logic                              is_ifft_i,
    input  logic                              bf_ready_i,
    output logic                              rd_en_o,
    output logic [N_LOG2-1:0]                 rd_addr_a_o,
    output logic [N_LOG2-1:0]                 rd_addr_b_o,
    output logic [tw_width(N_LOG2)-1:0]       tw_idx_o,
    output logic                              tw_conj_o,
    output logic                              bf_scale_o,
    output logic                              wr_en_o,
    output logic [N_LOG2-1:0]                 wr_addr_a_o,
    output logic [N_LOG2-1:0]                 wr_addr_b_o,
    output logic                              wr_scale_o,
    output logic [stage_width(N_LOG2)-1:0]    stage_o,
    output logic                              busy_o,
    output logic                              done_o
);

    localparam int unsigned PIPE_LAT = pipe_lat(RD_LAT, BF_LAT);
    localparam int unsigned TW_W     = tw_width(N_LOG2);
    localparam int unsigned ST_W     = stage_width(N_LOG2);
    localparam int unsigned J_W      = N_LOG2 - 1;
    localparam int unsigned CNT_W    = cnt_width(PIPE_LAT);
    localparam logic [ST_W-1:0] ST_LAST = ST_W'(N_LOG2 - 1);

`ifdef FFT_STAGE_SCALE_EN
    localparam int unsigned DL_W = 2 * N_LOG2 + 2;
`else
    localparam int unsigned DL_W = 2 * N_LOG2 + 1;
`endif

    fft_seq_state_t    state_q, state_d;
    logic [J_W-1:0]    j_q, j_d;
    logic [ST_W-1:0]   stage_q, stage_d;
    logic [CNT_W-1:0]  drain_q, drain_d;
    logic              ifft_q, ifft_d;

    // ---------------------------------------------------------------- FSM
    always_comb begin
        state_d = state_q;
        j_d     = j_q;
        stage_d = stage_q;
        drain_d = drain_q;
        ifft_d  = ifft_q;
        case (state_q)
            StIdle: begin
                if (start_i) begin
                    ifft_d  = is_ifft_i;
                    j_d     = '0;
                    stage_d = '0;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (bf_ready_i) begin
                    j_d = j_q + J_W'(1);
                    if (j_q == {J_W{1'b1}}) begin
                        state_d = StDrain;
                        drain_d = CNT_W'(PIPE_LAT);
                    end
                end
            end
            StDrain: begin
                drain_d = drain_q - CNT_W'(1);
                if (drain_q == CNT_W'(1)) begin
                    if (stage_q == ST_LAST) begin
                        state_d = StDone;
                    end else begin
                        stage_d = stage_q + ST_W'(1);
                        j_d     = '0;
                        state_d = StIssue;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            j_q     <= '0;
            stage_q <= '0;
            drain_q <= '0;
            ifft_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            j_q     <= j_d;
            stage_q <= stage_d;
            drain_q <= drain_d;
            ifft_q  <= ifft_d;
        end
    end

    // ---------------------------------------------------------- addressing
    logic [N_LOG2-1:0] j_ext, half, pos, grp, addr_a, tw_full;
    logic [ST_W-1:0]   tw_sh;

    always_comb begin
        j_ext   = {1'b0, j_q};
        half    = N_LOG2'(1) << stage_q;
        pos     = j_ext & (half - N_LOG2'(1));
        grp     = j_ext >> stage_q;
        // Group base is grp * 2^(s+1); position fills the low s bits.
        addr_a  = ((grp << stage_q) << 1) | pos;
        tw_sh   = ST_LAST - stage_q;
        tw_full = pos << tw_sh;
    end

    // Address fields are gated so every output reads 0 outside an issue.
    assign rd_en_o     = (state_q == StIssue) && bf_ready_i;
    assign rd_addr_a_o = rd_en_o ? addr_a : '0;
    assign rd_addr_b_o = rd_en_o ? (addr_a + half) : '0;
    assign tw_idx_o    = rd_en_o ? tw_full[TW_W-1:0] : '0;
    assign tw_conj_o   = rd_en_o & ifft_q;

    assign stage_o = stage_q;
    assign busy_o  = (state_q != StIdle);
    assign done_o  = (state_q == StDone);

    // ---------------------------------------------------------- write side
    logic [DL_W-1:0] dl_in, dl_out;

`ifdef FFT_STAGE_SCALE_EN
    assign bf_scale_o = rd_en_o;
    assign dl_in      = {rd_en_o, rd_addr_a_o, rd_addr_b_o, bf_scale_o};
    assign {wr_en_o, wr_addr_a_o, wr_addr_b_o, wr_scale_o} = dl_out;
`else
    assign bf_scale_o = 1'b0;
    assign wr_scale_o = 1'b0;
    assign dl_in      = {rd_en_o, rd_addr_a_o, rd_addr_b_o};
    assign {wr_en_o, wr_addr_a_o, wr_addr_b_o} = dl_out;
`endif

    fft_wr_delay_line #(
        .Depth (PIPE_LAT),
        .Width (DL_W)
    ) u_wr_delay_line (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (dl_in),
        .q_o    (dl_out)
    );

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Self-checking bench for fft_stage_sequencer with N_LOG2=3, RD_LAT=1, BF_LAT=3.
// Expected reads/writes are generated from the butterfly enumeration and pushed to
// queues before each transform; they are popped and compared as the DUT produces them.
module tb_fft_stage_sequencer;

    localparam int N_LOG2 = 3;
    localparam int N      = 1 << N_LOG2;
    localparam int PIPE   = 4;
`ifdef FFT_STAGE_SCALE_EN
    localparam bit EXP_SCALE = 1'b1;
`else
    localparam bit EXP_SCALE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_ni, start_i, is_ifft_i, bf_ready_i;
    logic       rd_en, tw_conj, bf_scale, wr_en, wr_scale, busy, done;
    logic [2:0] rd_a, rd_b, wr_a, wr_b;
    logic [1:0] tw_idx, stage;

    fft_stage_sequencer #(
        .N_LOG2 (N_LOG2),
        .RD_LAT (1),
        .BF_LAT (3)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .start_i     (start_i),
        .is_ifft_i   (is_ifft_i),
        .bf_ready_i  (bf_ready_i),
        .rd_en_o     (rd_en),
        .rd_addr_a_o (rd_a),
        .rd_addr_b_o (rd_b),
        .tw_idx_o    (tw_idx),
        .tw_conj_o   (tw_conj),
        .bf_scale_o  (bf_scale),
        .wr_en_o     (wr_en),
        .wr_addr_a_o (wr_a),
        .wr_addr_b_o (wr_b),
        .wr_scale_o  (wr_scale),
        .stage_o     (stage),
        .busy_o      (busy),
        .done_o      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int a;
        int b;
        int tw;
        int st;
    } exp_t;

    exp_t rd_q[$];
    exp_t wr_q[$];
    int   n_total = 0;
    int   n_bad   = 0;

    task automatic check_val(input string tag, input int got, input int exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One transform. stall_lo..stall_hi: cycles with bf_ready=0; rst_cyc: cycle with
    // rst_n=0 (-1 none); st_a/st_b: cycles with a stray start (-1 none).
    task automatic run_case(input int stall_lo, input int stall_hi, input bit ifft,
                            input int rst_cyc, input int st_a, input int st_b);
        int   c;
        int   done_cyc;
        int   end_cyc;
        int   busy_end;
        int   cyc;
        bit   exp_rd, exp_wr;
        exp_t e;

        rd_q.delete();
        wr_q.delete();
        c = 1;
        for (int s = 0; s < N_LOG2; s++) begin
            int half = 1 << s;
            int ngrp = N / (2 * half);
            for (int g = 0; g < ngrp; g++) begin
                for (int p = 0; p < half; p++) begin
                    while (c >= stall_lo && c <= stall_hi) c++;
                    e.cyc = c;
                    e.a   = g * 2 * half + p;
                    e.b   = e.a + half;
                    e.tw  = p * ngrp;
                    e.st  = s;
                    if (rst_cyc < 0 || c <= rst_cyc) rd_q.push_back(e);
                    e.cyc = c + PIPE;
                    if (rst_cyc < 0 || c + PIPE <= rst_cyc) wr_q.push_back(e);
                    c++;
                end
            end
            c += PIPE;
        end
        done_cyc = c;
        busy_end = (rst_cyc >= 0) ? rst_cyc : done_cyc;
        end_cyc  = (rst_cyc >= 0) ? rst_cyc + 6 : done_cyc + 4;

        start_i    = 1'b1;
        is_ifft_i  = ifft;
        bf_ready_i = 1'b1;
        @(posedge clk);  // edge 0: start sampled
        #1;
        cyc       = 1;
        start_i   = 1'b0;
        is_ifft_i = 1'b0;
        while (cyc <= end_cyc) begin
            bf_ready_i = !(cyc >= stall_lo && cyc <= stall_hi);
            start_i    = (cyc == st_a) || (cyc == st_b);
            rst_ni     = (cyc != rst_cyc);
            @(negedge clk);
            exp_rd = (rd_q.size() > 0) && (rd_q[0].cyc == cyc);
            exp_wr = (wr_q.size() > 0) && (wr_q[0].cyc == cyc);
            check_val($sformatf("rd_en@%0d", cyc), int'(rd_en), int'(exp_rd));
            check_val($sformatf("wr_en@%0d", cyc), int'(wr_en), int'(exp_wr));
            check_val($sformatf("busy@%0d", cyc), int'(busy), int'(cyc <= busy_end));
            check_val($sformatf("done@%0d", cyc), int'(done),
                      int'(rst_cyc < 0 && cyc == done_cyc));
            if (exp_rd) begin
                e = rd_q.pop_front();
                check_val($sformatf("rd_a@%0d", cyc), int'(rd_a), e.a);
                check_val($sformatf("rd_b@%0d", cyc), int'(rd_b), e.b);
                check_val($sformatf("tw@%0d", cyc), int'(tw_idx), e.tw);
                check_val($sformatf("stage@%0d", cyc), int'(stage), e.st);
                check_val($sformatf("conj@%0d", cyc), int'(tw_conj), int'(ifft));
                check_val($sformatf("bf_scale@%0d", cyc), int'(bf_scale), int'(EXP_SCALE));
            end else begin
                check_val($sformatf("bf_scale_idle@%0d", cyc), int'(bf_scale), 0);
            end
            if (exp_wr) begin
                e = wr_q.pop_front();
                check_val($sformatf("wr_a@%0d", cyc), int'(wr_a), e.a);
                check_val($sformatf("wr_b@%0d", cyc), int'(wr_b), e.b);
                check_val($sformatf("wr_scale@%0d", cyc), int'(wr_scale), int'(EXP_SCALE));
            end else begin
                check_val($sformatf("wr_scale_idle@%0d", cyc), int'(wr_scale), 0);
            end
            if (rst_cyc >= 0 && cyc == rst_cyc + 1) begin
                check_val("rst_outs_zero",
                          int'({rd_en, rd_a, rd_b, tw_idx, tw_conj, bf_scale, wr_en,
                                wr_a, wr_b, wr_scale, stage, busy, done}), 0);
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        rst_ni  = 1'b1;
        start_i = 1'b0;
        check_val("rd_left", rd_q.size(), 0);
        check_val("wr_left", wr_q.size(), 0);
        repeat (3) step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni     = 1'b0;
        start_i    = 1'b0;
        is_ifft_i  = 1'b0;
        bf_ready_i = 1'b0;
        repeat (3) step();
        @(negedge clk);
        check_val("reset_outs",
                  int'({rd_en, rd_a, rd_b, tw_idx, tw_conj, bf_scale, wr_en,
                        wr_a, wr_b, wr_scale, stage, busy, done}), 0);
        step();
        rst_ni = 1'b1;
        repeat (2) step();

        run_case(0, -1, 1'b0, -1, -1, -1);   // plain forward transform
        run_case(2, 3, 1'b1, -1, -1, -1);    // stall in stage 0, inverse
        run_case(0, -1, 1'b1, 10, -1, -1);   // reset mid-run
        run_case(0, -1, 1'b0, -1, 14, 25);   // stray starts while busy / in DONE

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
